phase_cycle_sequencer: RTL and testbench
========================================

PHASE_CYCLE_SEQUENCER -- requirements
Module: phase_cycle_sequencer

Interface
REQ-001 SHALL have parameter START_PULSE, default 4: width of sns_start_roi_o in clk_sys cycles (range 1..15).
REQ-002 SHALL have parameter SETTLE, default 16: clk_sys cycles modled_phase_o is held stable before start pulse (range 1..255).
REQ-003 SHALL have parameter TIMEOUT_W, default 24: width of the per-wait timeout counter.
REQ-004 SHALL have ports, one per line:
- clk_sys  in  1  system clock, 100 MHz; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  one-cycle pulse from register file (START_CYCLE write).
- abort_i  in  1  one-cycle pulse, stop the cycle.
- multicycle_i  in  1  1 = four phases, 0 = phase 0 only.
- phase0_i..phase3_i  in  8 each  MODLED_PHASE_0..3 register values.
- sns_enable_roi_i  in  1  sensor ROI-active, asynchronous to clk_sys.
- sns_start_roi_o  out  1  ROI start pulse to sensor.
- modled_phase_o  out  8  phase value applied to the LED modulator.
- phase_idx_o  out  2  index of the current phase.
- frame_start_o  out  1  one-cycle pulse on synchronised ROI rising edge (PPI frame sync).
- busy_o  out  1  high whenever state != IDLE.
- done_o  out  1  one-cycle pulse on normal completion.
- timeout_err_o  out  1  sticky error flag.

Function
REQ-005 SHALL pass sns_enable_roi_i through a 2-flop synchroniser plus one edge-detect register; all edges below refer to the synchronised signal (en_s).
REQ-006 SHALL implement states IDLE, SETUP, START, WAIT_EN, READOUT, NEXT.
REQ-007 IDLE: on start_i, SHALL latch phase0..3 and multicycle_i, set phase_idx to 0, clear timeout_err_o, and enter SETUP the next cycle.
REQ-008 SETUP: SHALL drive modled_phase_o from the latched phase[phase_idx], count SETTLE cycles, then enter START.
REQ-009 START: SHALL hold sns_start_roi_o high for exactly START_PULSE cycles, then enter WAIT_EN.
REQ-010 WAIT_EN: SHALL advance to READOUT only on an en_s rising edge, and SHALL pulse frame_start_o in the same cycle as the transition. If en_s is already high on entry, it SHALL wait for a fresh rising edge.
REQ-011 READOUT: SHALL advance to NEXT on an en_s falling edge.
REQ-012 NEXT (one cycle):
- If multicycle latched and phase_idx < 3: increment phase_idx and go to SETUP.
- Otherwise: pulse done_o and go to IDLE.
REQ-013 Timeout counter:
- Clears on entry to WAIT_EN and on entry to READOUT; increments every cycle in those states.
- On reaching all-ones: set timeout_err_o, go to IDLE, no done_o.
REQ-014 abort_i SHALL force IDLE next cycle from any state:
- sns_start_roi_o low immediately (registered, next edge).
- No done_o, timeout_err_o unchanged.
- abort_i has priority over a simultaneous start_i.
REQ-015 start_i while busy_o=1 SHALL be ignored; register input changes while busy SHALL NOT affect the running cycle.
REQ-016 In IDLE, modled_phase_o SHALL hold its last value and phase_idx_o SHALL hold its last value.
REQ-017 All outputs SHALL be registered; single-phase latency from start_i to sns_start_roi_o rising = SETTLE+2 cycles.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously clear state to IDLE, synchroniser flops, counters, phase_idx_o, modled_phase_o, sns_start_roi_o, frame_start_o, busy_o, done_o and timeout_err_o to 0.
REQ-019 Reset deasserted mid-cycle SHALL resume in IDLE with no spurious frame_start_o/done_o, even if sns_enable_roi_i is high.

Verification
REQ-020 Single-phase run:
- Stimulus: multicycle=0, phase0=0x01, start; sensor raises enable 1000 cycles after start_roi, drops it 5000 cycles later.
- Required: modled_phase_o=0x01, start_roi high 4 cycles at start+18, exactly one frame_start_o, one done_o, busy_o low afterward.
REQ-021 Multicycle run:
- Stimulus: phases 0x01/0x02/0x03/0x04, multicycle=1.
- Required: four start_roi pulses with phase_idx 0..3 and matching modled_phase_o, four frame_start_o, one done_o after the fourth enable fall.
REQ-022 Timeout:
- Stimulus: TIMEOUT_W=8, enable never rises.
- Required: timeout_err_o=1 and IDLE 255 cycles after entering WAIT_EN, no done_o; next start clears the flag.
REQ-023 Abort and simultaneous events:
- Stimulus: abort during READOUT of phase 2.
- Required: busy_o=0 next cycle, no done_o.
- Stimulus: abort and start in the same cycle from IDLE.
- Required: stays IDLE.
REQ-024 Stale-enable and ignored-start:
- Stimulus: enable already high when WAIT_EN is entered.
- Required: no advance until enable falls and rises again.
- Stimulus: start_i while busy.
- Required: no restart, phase_idx_o unchanged.
REQ-025 Reset mid-operation:
- Stimulus: rst_n low during START.
- Required: sns_start_roi_o=0 immediately, all outputs 0.

Source files
------------

// File: rtl/phase_cycle_sequencer.sv
// Phase cycle sequencer: steps the LED modulator through one or four phases,
// handshaking each phase with the sensor through ROI start pulse and ROI enable.
`timescale 1ns/1ps

module phase_cycle_sequencer #(
  parameter int START_PULSE = 4,
  parameter int SETTLE      = 16,
  parameter int TIMEOUT_W   = 24
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       multicycle_i,
  input  logic [7:0] phase0_i,
  input  logic [7:0] phase1_i,
  input  logic [7:0] phase2_i,
  input  logic [7:0] phase3_i,
  input  logic       sns_enable_roi_i,
  output logic       sns_start_roi_o,
  output logic [7:0] modled_phase_o,
  output logic [1:0] phase_idx_o,
  output logic       frame_start_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       timeout_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT_EN,
    ST_READOUT,
    ST_NEXT
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE);
  localparam logic [7:0] PULSE_LAST  = 8'(START_PULSE - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_ALL  = '1;
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TMO_ALL - TIMEOUT_W'(1);

  state_t state;
  state_t next_state;

  logic                 en_meta;
  logic                 en_s;
  logic                 en_d;
  logic                 en_rise;
  logic                 en_fall;

  logic [3:0][7:0]      phase_lat;
  logic                 multi_lat;
  logic [7:0]           step_cnt;
  logic [TIMEOUT_W-1:0] tmo_cnt;

  logic                 start_acc;
  logic                 frame_evt;
  logic                 done_evt;
  logic                 tmo_evt;
  logic                 idx_inc;

  // Sensor enable crosses from the sensor domain; en_d only feeds edge detection.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      en_meta <= 1'b0;
      en_s    <= 1'b0;
      en_d    <= 1'b0;
    end else begin
      en_meta <= sns_enable_roi_i;
      en_s    <= en_meta;
      en_d    <= en_s;
    end
  end

  assign en_rise = en_s & ~en_d;
  assign en_fall = ~en_s & en_d;

  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    frame_evt  = 1'b0;
    done_evt   = 1'b0;
    tmo_evt    = 1'b0;
    idx_inc    = 1'b0;
    if (abort_i) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            start_acc  = 1'b1;
            next_state = ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (step_cnt == SETTLE_LAST) next_state = ST_START;
        end
        ST_START: begin
          if (step_cnt == PULSE_LAST) next_state = ST_WAIT_EN;
        end
        ST_WAIT_EN: begin
          // Only a fresh rising edge counts; a level already high is stale.
          if (en_rise) begin
            frame_evt  = 1'b1;
            next_state = ST_READOUT;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_evt    = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_READOUT: begin
          if (en_fall) begin
            next_state = ST_NEXT;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo_evt    = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_NEXT: begin
          if (multi_lat && (phase_idx_o != 2'd3)) begin
            idx_inc    = 1'b1;
            next_state = ST_SETUP;
          end else begin
            done_evt   = 1'b1;
            next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      sns_start_roi_o <= 1'b0;
      modled_phase_o  <= 8'h00;
      phase_idx_o     <= 2'd0;
      frame_start_o   <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      timeout_err_o   <= 1'b0;
      phase_lat       <= '0;
      multi_lat       <= 1'b0;
      step_cnt        <= 8'h00;
      tmo_cnt         <= '0;
    end else begin
      state           <= next_state;
      sns_start_roi_o <= (next_state == ST_START);
      busy_o          <= (next_state != ST_IDLE);
      frame_start_o   <= frame_evt;
      done_o          <= done_evt;

      if (start_acc) begin
        phase_lat     <= {phase3_i, phase2_i, phase1_i, phase0_i};
        multi_lat     <= multicycle_i;
        phase_idx_o   <= 2'd0;
        timeout_err_o <= 1'b0;
      end else if (idx_inc) begin
        phase_idx_o   <= phase_idx_o + 2'd1;
      end

      if (tmo_evt) timeout_err_o <= 1'b1;

      // The LED value settles from the latched copy for SETTLE cycles before the pulse.
      if (state == ST_SETUP) modled_phase_o <= phase_lat[phase_idx_o];

      if ((next_state != state) || (state == ST_IDLE)) step_cnt <= 8'h00;
      else                                             step_cnt <= step_cnt + 8'h01;

      if (next_state != state)
        tmo_cnt <= '0;
      else if ((state == ST_WAIT_EN) || (state == ST_READOUT))
        tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_cycle_sequencer.sv
// Self-checking bench for phase_cycle_sequencer: vector table of full cycles plus
// hand-written timeout, abort and reset sequences.
`timescale 1ns/1ps

module tb_phase_cycle_sequencer;

  localparam int SETTLE      = 16;
  localparam int START_PULSE = 4;

  typedef struct {
    logic            multi;
    logic [3:0][7:0] ph;
    int              en_delay;
    int              en_hold;
    int              inject;
    int              exp_phases;
    int              exp_frames;
    int              exp_done;
  } vec_t;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] ph;
  } exp_t;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       start_i;
  logic       abort_i;
  logic       multicycle_i;
  logic [7:0] phase0_i, phase1_i, phase2_i, phase3_i;
  logic       sns_enable_roi_i;

  logic       roi, frame, busy, done, terr;
  logic [7:0] modled;
  logic [1:0] idx;
  logic       t_roi, t_frame, t_busy, t_done, t_err;
  logic [7:0] t_modled;
  logic [1:0] t_idx;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   frame_cnt = 0;
  int   done_cnt = 0;
  int   t_done_cnt = 0;
  exp_t sb[$];
  vec_t vecs[6];

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (frame)  frame_cnt  = frame_cnt + 1;
      if (done)   done_cnt   = done_cnt + 1;
      if (t_done) t_done_cnt = t_done_cnt + 1;
    end
  end

  phase_cycle_sequencer dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .multicycle_i(multicycle_i), .phase0_i(phase0_i), .phase1_i(phase1_i),
    .phase2_i(phase2_i), .phase3_i(phase3_i), .sns_enable_roi_i(sns_enable_roi_i),
    .sns_start_roi_o(roi), .modled_phase_o(modled), .phase_idx_o(idx),
    .frame_start_o(frame), .busy_o(busy), .done_o(done), .timeout_err_o(terr)
  );

  phase_cycle_sequencer #(.TIMEOUT_W(8)) dut_tmo (
    .clk_sys(clk_sys), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
    .multicycle_i(multicycle_i), .phase0_i(phase0_i), .phase1_i(phase1_i),
    .phase2_i(phase2_i), .phase3_i(phase3_i), .sns_enable_roi_i(sns_enable_roi_i),
    .sns_start_roi_o(t_roi), .modled_phase_o(t_modled), .phase_idx_o(t_idx),
    .frame_start_o(t_frame), .busy_o(t_busy), .done_o(t_done), .timeout_err_o(t_err)
  );

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk_sys);
    #1 start_i = 1'b1;
    start_cyc = cyc;
    @(posedge clk_sys);
    #1 start_i = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk_sys);
    #1 abort_i = 1'b1;
    @(posedge clk_sys);
    #1 abort_i = 1'b0;
  endtask

  task automatic pulse_both();
    @(posedge clk_sys);
    #1 start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk_sys);
    #1 start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  task automatic wait_roi_rise(output int at_cyc, output bit ok);
    ok = 1'b0;
    at_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (roi === 1'b1) begin
        ok = 1'b1;
        at_cyc = cyc;
        break;
      end
    end
  endtask

  function automatic vec_t mk_vec(input logic m, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d, input int dl,
                                  input int hd, input int inj, input int ep, input int ef,
                                  input int ed);
    vec_t v;
    v.multi = m;
    v.ph = {d, c, b, a};
    v.en_delay = dl;
    v.en_hold = hd;
    v.inject = inj;
    v.exp_phases = ep;
    v.exp_frames = ef;
    v.exp_done = ed;
    return v;
  endfunction

  // Drives the register values, queues what each phase must show, then
  // scrambles the inputs so that only the latched copy can be in use.
  task automatic applyStimulus(input vec_t v, input int nph);
    exp_t e;
    multicycle_i = v.multi;
    phase0_i = v.ph[0];
    phase1_i = v.ph[1];
    phase2_i = v.ph[2];
    phase3_i = v.ph[3];
    sb.delete();
    for (int i = 0; i < nph; i++) begin
      e.idx = 2'(i);
      e.ph = v.ph[i];
      sb.push_back(e);
    end
    pulse_start();
    multicycle_i = ~v.multi;
    phase0_i = 8'($urandom);
    phase1_i = 8'($urandom);
    phase2_i = 8'($urandom);
    phase3_i = 8'($urandom);
  endtask

  task automatic run_vector(input vec_t v);
    int nph, f0, d0, pulses, rise_cyc, w, last;
    bit ok, aborted;
    exp_t e;
    nph = v.multi ? 4 : 1;
    f0 = frame_cnt;
    d0 = done_cnt;
    pulses = 0;
    last = 0;
    aborted = 1'b0;
    sns_enable_roi_i = (v.inject == 3);
    repeat (5) tick();
    applyStimulus(v, nph);
    for (int p = 0; p < nph; p++) begin
      wait_roi_rise(rise_cyc, ok);
      checkOutput("roi_rise_seen", 32'(ok), 32'd1);
      if (!ok) break;
      pulses++;
      last = p;
      e = sb.pop_front();
      checkOutput("phase_idx", 32'(idx), 32'(e.idx));
      checkOutput("modled_phase", 32'(modled), 32'(e.ph));
      if (p == 0) checkOutput("start_latency", rise_cyc - start_cyc, SETTLE + 2);
      w = 1;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (!roi) break;
        w++;
      end
      checkOutput("roi_width", w, START_PULSE);
      if (v.inject == 2 && p == 1) begin
        pulse_start();
        tick();
        checkOutput("ignored_start_idx", 32'(idx), 32'd1);
        checkOutput("ignored_start_busy", 32'(busy), 32'd1);
      end
      if (v.inject == 3 && p == 0) begin
        repeat (40) tick();
        checkOutput("stale_en_no_frame", frame_cnt - f0, 0);
        checkOutput("stale_en_busy", 32'(busy), 32'd1);
        sns_enable_roi_i = 1'b0;
        repeat (10) tick();
        checkOutput("stale_fall_no_frame", frame_cnt - f0, 0);
      end
      repeat (v.en_delay) tick();
      sns_enable_roi_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (frame_cnt - f0 == p + 1) break;
      end
      checkOutput("frame_per_phase", frame_cnt - f0, p + 1);
      if (v.inject == 1 && p == 2) begin
        pulse_abort();
        tick();
        checkOutput("abort_busy_low", 32'(busy), 32'd0);
        sns_enable_roi_i = 1'b0;
        aborted = 1'b1;
        break;
      end
      repeat (v.en_hold) tick();
      sns_enable_roi_i = 1'b0;
    end
    if (!aborted) begin
      for (int i = 0; i < 60; i++) begin
        tick();
        if (!busy) break;
      end
    end
    repeat (3) tick();
    checkOutput("roi_pulses", pulses, v.exp_phases);
    checkOutput("frame_count", frame_cnt - f0, v.exp_frames);
    checkOutput("done_count", done_cnt - d0, v.exp_done);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_hold_idx", 32'(idx), last);
    checkOutput("idle_hold_modled", 32'(modled), 32'(v.ph[last]));
    sb.delete();
  endtask

  initial begin
    int f0, d0, td0, n, rc;
    bit ok;

    vecs[0] = mk_vec(1'b0, 8'h01, 8'h77, 8'h88, 8'h99, 1000, 5000, 0, 1, 1, 1);
    vecs[1] = mk_vec(1'b1, 8'h01, 8'h02, 8'h03, 8'h04, 30, 40, 0, 4, 4, 1);
    vecs[2] = mk_vec(1'b1, 8'hFF, 8'h00, 8'h80, 8'h7F, 12, 9, 2, 4, 4, 1);
    vecs[3] = mk_vec(1'b0, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 15, 15, 3, 1, 1, 1);
    vecs[4] = mk_vec(1'b1, 8'h11, 8'h22, 8'h33, 8'h44, 20, 20, 1, 3, 3, 0);
    vecs[5] = mk_vec(1'b0, 8'h00, 8'hC3, 8'hC3, 8'hC3, 5, 5, 0, 1, 1, 1);

    rst_n = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    multicycle_i = 1'b1;
    phase0_i = 8'h5A;
    phase1_i = 8'h5A;
    phase2_i = 8'h5A;
    phase3_i = 8'h5A;
    sns_enable_roi_i = 1'b1;

    #23;
    checkOutput("reset_outputs", 32'({roi, modled, idx, frame, busy, done, terr}), 32'd0);
    checkOutput("reset_tmo_outputs", 32'({t_roi, t_modled, t_idx, t_busy, t_err}), 32'd0);
    #4 rst_n = 1'b1;
    repeat (8) tick();
    checkOutput("release_no_frame", frame_cnt, 0);
    checkOutput("release_no_done", done_cnt, 0);
    checkOutput("release_idle", 32'(busy), 32'd0);
    sns_enable_roi_i = 1'b0;
    repeat (5) tick();

    for (int k = 0; k < 6; k++) begin
      $display("[TB] vector %0d", k);
      run_vector(vecs[k]);
    end

    $display("[TB] timeout sequence");
    pulse_abort();
    multicycle_i = 1'b0;
    phase0_i = 8'h5C;
    td0 = t_done_cnt;
    pulse_start();
    wait_roi_rise(rc, ok);
    checkOutput("tmo_roi_rise_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (!t_roi) break;
      tick();
    end
    n = 0;
    while (!t_err && n < 400) begin
      tick();
      n++;
    end
    checkOutput("timeout_cycles", n, 255);
    checkOutput("timeout_err_set", 32'(t_err), 32'd1);
    checkOutput("timeout_idle", 32'(t_busy), 32'd0);
    checkOutput("timeout_no_done", t_done_cnt - td0, 0);
    checkOutput("wide_counter_still_waiting", 32'(busy), 32'd1);
    pulse_abort();
    tick();
    checkOutput("abort_keeps_err", 32'(t_err), 32'd1);
    pulse_start();
    tick();
    checkOutput("start_clears_err", 32'(t_err), 32'd0);
    checkOutput("start_after_tmo_busy", 32'(t_busy), 32'd1);
    pulse_abort();
    repeat (3) tick();

    $display("[TB] abort with start sequence");
    pulse_both();
    tick();
    checkOutput("abort_start_busy", 32'(busy), 32'd0);
    repeat (25) tick();
    checkOutput("abort_start_stays_idle", 32'({busy, roi}), 32'd0);

    $display("[TB] reset during start pulse");
    multicycle_i = 1'b0;
    phase0_i = 8'h9E;
    pulse_start();
    wait_roi_rise(rc, ok);
    checkOutput("rst_roi_rise_seen", 32'(ok), 32'd1);
    checkOutput("rst_modled_before", 32'(modled), 32'h9E);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_roi_immediate", 32'(roi), 32'd0);
    checkOutput("reset_all_outputs", 32'({roi, modled, idx, frame, busy, done, terr}), 32'd0);
    sns_enable_roi_i = 1'b1;
    #9 rst_n = 1'b1;
    f0 = frame_cnt;
    d0 = done_cnt;
    repeat (10) tick();
    checkOutput("reset_resume_no_frame", frame_cnt - f0, 0);
    checkOutput("reset_resume_no_done", done_cnt - d0, 0);
    checkOutput("reset_resume_idle", 32'(busy), 32'd0);
    sns_enable_roi_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
